// File: rtl/ucounter_pkg.sv
// ----------------------------------------------------------------------------
// ucounter_pkg
// Shared constants for the cascaded up/down counter. These name the encodings
// of the direction and limit-mode controls so that the segment and top-level
// logic read in terms of intent rather than raw bit values.
// ----------------------------------------------------------------------------
package ucounter_pkg;

    // Direction encoding for the updown control
    localparam logic UC_UP   = 1'b1;
    localparam logic UC_DOWN = 1'b0;

    // Limit behaviour encoding for the wrapstop control
    localparam logic UC_WRAP = 1'b1;
    localparam logic UC_STOP = 1'b0;

endpackage : ucounter_pkg

// File: rtl/ucounter_seg.sv
// ----------------------------------------------------------------------------
// ucounter_seg
// One SEG_W-bit slice of the cascaded counter. The slice advances by one in
// the selected direction when both the global step enable and its carry-in
// are high. It has no notion of stopping at a limit; that decision belongs to
// the top level, which gates the step input.
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   synchronous active-high reset (slice -> 0)
//   ci      in   carry/borrow in from the lower slice (en for slice 0)
//   updown  in   1 = count up, 0 = count down
//   step    in   global step enable (already gated by the stop decision)
//   ld      in   load ld_val
//   set     in   force slice to all ones
//   ld_val  in   preload value for this slice
//   seg     out  registered slice value
//   co      out  carry/borrow out: ci and slice at its directional limit
// ----------------------------------------------------------------------------
module ucounter_seg
    import ucounter_pkg::*;
#(
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ci,
    input  logic             updown,
    input  logic             step,
    input  logic             ld,
    input  logic             set,
    input  logic [SEG_W-1:0] ld_val,
    output logic [SEG_W-1:0] seg,
    output logic             co
);

    localparam logic [SEG_W-1:0] SEG_ONE   = {{(SEG_W-1){1'b0}}, 1'b1};
    localparam logic [SEG_W-1:0] SEG_ZERO  = {SEG_W{1'b0}};
    localparam logic [SEG_W-1:0] SEG_ONES  = {SEG_W{1'b1}};

    logic [SEG_W-1:0] seg_q;
    logic [SEG_W-1:0] seg_d;
    logic             at_lim_s;

    // Slice is at its directional limit: all ones going up, zero going down
    always_comb begin
        at_lim_s = 1'b0;
        if (updown == UC_UP) begin
            at_lim_s = (seg_q == SEG_ONES);
        end else begin
            at_lim_s = (seg_q == SEG_ZERO);
        end
    end

    assign co  = ci & at_lim_s;
    assign seg = seg_q;

    // Next slice value: set > load > step
    always_comb begin
        seg_d = seg_q;
        if (set) begin
            seg_d = SEG_ONES;
        end else if (ld) begin
            seg_d = ld_val;
        end else if (step && ci) begin
            if (updown == UC_UP) begin
                seg_d = seg_q + SEG_ONE;
            end else begin
                seg_d = seg_q - SEG_ONE;
            end
        end else begin
            seg_d = seg_q;
        end
    end

    // Slice register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q <= SEG_ZERO;
        end else begin
            seg_q <= seg_d;
        end
    end

endmodule : ucounter_seg

// File: rtl/ucounter_cascade.sv
// ----------------------------------------------------------------------------
// ucounter_cascade
// Up/down counter of W = SEG_W*NUM_SEG bits built from NUM_SEG cascaded
// ucounter_seg slices. The carry/borrow chain is combinational, so the whole
// counter moves by one per enabled cycle with no ripple across cycles.
// The top level decides whether a step at the limit wraps or is suppressed,
// and registers the per-slice carry flags, the overflow pulse and the
// sticky overflow.
//
// Ports
//   clk             in   rising-edge clock
//   reset           in   synchronous active-high reset
//   en              in   count enable
//   load            in   load preld_val
//   set             in   force all ones (beats load)
//   preld_val       in   W-bit preload value
//   updown          in   1 = up, 0 = down
//   wrapstop        in   1 = wrap at limit, 0 = hold at limit
//   clr_sticky      in   clear overflow_sticky (a new overflow wins)
//   dcount          out  registered count
//   seg_carry       out  registered per-slice carry/borrow of the last step
//   overflow        out  registered pulse: step attempted at the limit
//   overflow_sticky out  registered latched overflow
//   tc              out  combinational terminal count for current direction
// ----------------------------------------------------------------------------
module ucounter_cascade
    import ucounter_pkg::*;
#(
    parameter int SEG_W   = 8,
    parameter int NUM_SEG = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     load,
    input  logic                     set,
    input  logic [SEG_W*NUM_SEG-1:0] preld_val,
    input  logic                     updown,
    input  logic                     wrapstop,
    input  logic                     clr_sticky,
    output logic [SEG_W*NUM_SEG-1:0] dcount,
    output logic [NUM_SEG-1:0]       seg_carry,
    output logic                     overflow,
    output logic                     overflow_sticky,
    output logic                     tc
);

    localparam int W = SEG_W * NUM_SEG;

    logic [NUM_SEG-1:0] ci_s;
    logic [NUM_SEG-1:0] co_s;
    logic               stop_s;
    logic               step_s;

    logic [NUM_SEG-1:0] seg_carry_q;
    logic [NUM_SEG-1:0] seg_carry_d;
    logic               overflow_q;
    logic               overflow_d;
    logic               sticky_q;
    logic               sticky_d;

    // Terminal count in the current direction
    always_comb begin
        tc = 1'b0;
        if (updown == UC_UP) begin
            tc = (dcount == {W{1'b1}});
        end else begin
            tc = (dcount == {W{1'b0}});
        end
    end

    // In stop mode a step at the limit is suppressed for every slice; since
    // all slices are at their limit, gating the shared step is enough.
    assign stop_s = tc & (wrapstop == UC_STOP);
    assign step_s = en & ~stop_s;

    for (genvar i = 0; i < NUM_SEG; i++) begin : g_seg
        if (i == 0) begin : g_first
            assign ci_s[i] = en;
        end else begin : g_next
            assign ci_s[i] = co_s[i-1];
        end

        ucounter_seg #(
            .SEG_W (SEG_W)
        ) u_seg (
            .clk    (clk),
            .reset  (reset),
            .ci     (ci_s[i]),
            .updown (updown),
            .step   (step_s),
            .ld     (load),
            .set    (set),
            .ld_val (preld_val[i*SEG_W +: SEG_W]),
            .seg    (dcount[i*SEG_W +: SEG_W]),
            .co     (co_s[i])
        );
    end

    // Next values of carry flags, overflow pulse and sticky overflow
    always_comb begin
        seg_carry_d = {NUM_SEG{1'b0}};
        overflow_d  = 1'b0;
        sticky_d    = sticky_q;
        if (set || load) begin
            seg_carry_d = {NUM_SEG{1'b0}};
            overflow_d  = 1'b0;
        end else if (en) begin
            // co_s is only meaningful when the step really happens
            seg_carry_d = step_s ? co_s : {NUM_SEG{1'b0}};
            overflow_d  = tc;
        end else begin
            seg_carry_d = {NUM_SEG{1'b0}};
            overflow_d  = 1'b0;
        end
        if (overflow_d) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    // Status registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_carry_q <= {NUM_SEG{1'b0}};
            overflow_q  <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            seg_carry_q <= seg_carry_d;
            overflow_q  <= overflow_d;
            sticky_q    <= sticky_d;
        end
    end

    assign seg_carry       = seg_carry_q;
    assign overflow        = overflow_q;
    assign overflow_sticky = sticky_q;

endmodule : ucounter_cascade
